mask_gen: RTL and testbench
===========================

# mask_gen

Transmit-side companion of the serial mask applier. Accepts a data word over a valid/ready handshake and compares it bit-serially against the last word it published. It then emits a `{mask, data}` pair plus a one-cycle start pulse that drives the applier's pulse input. A guard interval keeps the pair stable until the applier has finished its bit-serial update. Sits between the word source and the mask applier.

## Interface
- `DATA_LEN`, 8: data word width.
- `MASK_LEN`, 8: mask width; must equal `DATA_LEN`.
- `GUARD_CYC`, 10: cycles `mask_o`/`data_o` are held after the pulse; must be ≥ `DATA_LEN`+2.
- `clk_i` in 1: clock.
- `rst_N_i` in 1: reset, asynchronous, active-low.
- `data_valid_i` in 1: source has a word.
- `data_i` in `DATA_LEN`: source word.
- `data_ready_o` out 1: block can accept a word.
- `mask_o` out `MASK_LEN`: bits differing from the previously published word.
- `data_o` out `DATA_LEN`: published word.
- `outsignal_pulse_o` out 1: one-cycle start strobe to the applier.
- `busy_o` out 1: high in every state except IDLE.
- `change_cnt_o` out $clog2(`DATA_LEN`+1): number of ones in `mask_o`. Present only with the macro.

## Operation
- States:
  - INIT, entered on reset, lasts one cycle, then IDLE.
  - IDLE.
  - SCAN.
  - EMIT, one cycle.
  - GUARD.
- Registers and reset values:
  - `ref_reg` = 0. This matches the applier's reset output of 0.
  - `data_latch` = 0.
  - `scan_mask` = 0.
  - `bit_cnt` = 0.
  - `guard_cnt` = 0.
  - `mask_o` = 0, `data_o` = 0, `outsignal_pulse_o` = 0.
  - `data_ready_o` = 0, `busy_o` = 1 during INIT.
- IDLE:
  - `data_ready_o` = 1.
  - A handshake (`data_valid_i`&`data_ready_o` at an edge) latches `data_i` into `data_latch`, clears `scan_mask`, sets `bit_cnt`=0 and moves to SCAN.
- SCAN:
  - Each cycle, `scan_mask[bit_cnt]` <= `data_latch[bit_cnt]` ^ `ref_reg[bit_cnt]`, and `bit_cnt`++.
  - After bit `DATA_LEN`-1, move to EMIT.
  - Exactly `DATA_LEN` cycles.
- EMIT:
  - If `scan_mask` is nonzero:
    - `mask_o` <= `scan_mask`, `data_o` <= `data_latch`, `ref_reg` <= `data_latch`.
    - `outsignal_pulse_o` = 1 for exactly this cycle.
    - Next state GUARD with `guard_cnt`=0.
  - If `scan_mask` is zero: no pulse, outputs and `ref_reg` unchanged, next state IDLE.
- GUARD: `guard_cnt` increments each cycle; when it reaches `GUARD_CYC`-1, move to IDLE.
- `data_i`/`data_valid_i` changes outside the IDLE handshake are ignored.
- A `data_valid_i` held through busy is accepted on the first IDLE cycle.
- `mask_o`/`data_o` change only at the EMIT edge and are otherwise stable.
- Reset asserted in any state: all registers return to reset values immediately. The in-flight word is discarded. `ref_reg` returns to 0, in step with the applier.

## Timing
- Handshake at edge T:
  - SCAN occupies cycles T+1..T+`DATA_LEN`.
  - EMIT is at cycle T+`DATA_LEN`+1. `outsignal_pulse_o` is high during that cycle, with `mask_o`/`data_o` valid from its start.
- `data_ready_o` returns high:
  - Changed word: at T+`DATA_LEN`+2+`GUARD_CYC`.
  - Unchanged word: at T+`DATA_LEN`+2.
- Back-to-back throughput, changed words at defaults: one word per 20 cycles.
- `outsignal_pulse_o` is decoded from registered state only; it is never combinational from inputs.

## Configuration
- `MASK_GEN_CHGCNT_EN` defined:
  - Adds port `change_cnt_o` and an accumulator, reset to 0 at the handshake.
  - The accumulator increments by 1 for each differing bit during SCAN.
  - It is copied to `change_cnt_o` at the EMIT edge only when a pulse is emitted. `change_cnt_o` resets to 0.
- Undefined: port and logic absent; all other behaviour identical.

## Test plan
- Reset release: `data_ready_o`=0 for one cycle (INIT), then 1. `mask_o`=`data_o`=0, pulse=0, `change_cnt_o`=0.
- Send 0xA5 after reset, handshake at T:
  - Pulse high only at T+9, with `mask_o`=0xA5, `data_o`=0xA5, `change_cnt_o`=4.
  - `data_ready_o` low until T+20.
- Resend 0xA5: no pulse, `mask_o` stays 0xA5, `data_ready_o` high again at T+10.
- Send 0x3C after 0xA5: `mask_o`=0x99, `data_o`=0x3C, `change_cnt_o`=4. Output pair stable for all 10 GUARD cycles.
- Hold `data_valid_i`=1 while changing `data_i` through SCAN and GUARD: only the word present at the IDLE handshake is used. The next word is accepted on the first IDLE cycle.
- Assert `rst_N_i` at SCAN cycle 4 of 0xFF:
  - Outputs go to 0 asynchronously, no pulse.
  - After release, sending 0x01 yields `mask_o`=0x01.

Source files
------------

// File: rtl/mask_gen.sv
// ---------------------------------------------------------------------------
// mask_gen
//
// Transmit-side companion of the serial mask applier. It accepts a data word
// over a valid/ready handshake and compares it bit-serially against the last
// word it published. If any bit differs, it publishes a {mask, data} pair and
// fires a one-cycle start strobe for the applier. The pair is then held
// through a guard interval so the applier can finish its bit-serial update.
//
// Parameters
//   DATA_LEN   data word width
//   MASK_LEN   mask width, must equal DATA_LEN
//   GUARD_CYC  hold cycles after the strobe, must be >= DATA_LEN+2
//
// Ports
//   clk_i              clock
//   rst_N_i            asynchronous active-low reset
//   data_valid_i       source has a word
//   data_i             source word
//   data_ready_o       block can accept a word (IDLE only)
//   mask_o             bits that differ from the previously published word
//   data_o             published word
//   outsignal_pulse_o  one-cycle start strobe to the applier
//   busy_o             high in every state except IDLE
//   change_cnt_o       number of ones in mask_o (only with MASK_GEN_CHGCNT_EN)
//
// Optional feature
//   Define MASK_GEN_CHGCNT_EN to add change_cnt_o and its accumulator.
// ---------------------------------------------------------------------------
module mask_gen #(
    parameter int DATA_LEN  = 8,
    parameter int MASK_LEN  = 8,
    parameter int GUARD_CYC = 10
) (
    input  logic                clk_i,
    input  logic                rst_N_i,
    input  logic                data_valid_i,
    input  logic [DATA_LEN-1:0] data_i,
    output logic                data_ready_o,
    output logic [MASK_LEN-1:0] mask_o,
    output logic [DATA_LEN-1:0] data_o,
    output logic                outsignal_pulse_o,
    output logic                busy_o
`ifdef MASK_GEN_CHGCNT_EN
    ,
    output logic [$clog2(DATA_LEN+1)-1:0] change_cnt_o
`endif
);

    localparam int BIT_W   = (DATA_LEN > 1) ? $clog2(DATA_LEN) : 1;
    localparam int GUARD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_GUARD
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [DATA_LEN-1:0]  ref_reg;
    logic [DATA_LEN-1:0]  data_latch;
    logic [MASK_LEN-1:0]  scan_mask;
    logic [MASK_LEN-1:0]  scan_mask_nxt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [GUARD_W-1:0]   guard_cnt;
    logic                 diff_bit;
    logic                 last_bit;
    logic                 emit_hit;

`ifdef MASK_GEN_CHGCNT_EN
    logic [$clog2(DATA_LEN+1)-1:0] chg_acc;
    logic [$clog2(DATA_LEN+1)-1:0] chg_acc_nxt;
`endif

    // Bit-serial compare of the latched word against the last published one.
    // The final scan step folds in the last bit combinationally, so the
    // "anything changed" decision is already known at the edge that enters
    // EMIT. That lets the pair and the strobe be valid from the very start of
    // the EMIT cycle.
    assign diff_bit = data_latch[bit_cnt] ^ ref_reg[bit_cnt];
    assign last_bit = (bit_cnt == BIT_W'(DATA_LEN - 1));
    assign emit_hit = last_bit && (scan_mask_nxt != '0);

    always_comb begin
        scan_mask_nxt          = scan_mask;
        scan_mask_nxt[bit_cnt] = diff_bit;
    end

`ifdef MASK_GEN_CHGCNT_EN
    // Running count of differing bits, including the bit scanned this cycle.
    assign chg_acc_nxt = chg_acc + $bits(chg_acc)'(diff_bit);
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_N_i) begin
        if (!rst_N_i) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. EMIT goes to GUARD only when a strobe was issued;
    // the strobe flop doubles as the record of that decision.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_INIT:  state_nxt = ST_IDLE;
            ST_IDLE:  if (data_valid_i) state_nxt = ST_SCAN;
            ST_SCAN:  if (last_bit) state_nxt = ST_EMIT;
            ST_EMIT:  state_nxt = outsignal_pulse_o ? ST_GUARD : ST_IDLE;
            ST_GUARD: if (guard_cnt == GUARD_W'(GUARD_CYC - 1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // Handshake outputs, decoded from the registered state only.
    always_comb begin
        data_ready_o = (state == ST_IDLE);
        busy_o       = (state != ST_IDLE);
    end

    // Datapath. The published pair and ref_reg move together so the block's
    // notion of "last published word" always matches what the applier holds;
    // reset clears ref_reg to 0 in step with the applier's own reset.
    always_ff @(posedge clk_i or negedge rst_N_i) begin
        if (!rst_N_i) begin
            ref_reg           <= '0;
            data_latch        <= '0;
            scan_mask         <= '0;
            bit_cnt           <= '0;
            guard_cnt         <= '0;
            mask_o            <= '0;
            data_o            <= '0;
            outsignal_pulse_o <= 1'b0;
`ifdef MASK_GEN_CHGCNT_EN
            chg_acc           <= '0;
            change_cnt_o      <= '0;
`endif
        end else begin
            outsignal_pulse_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (data_valid_i) begin
                        data_latch <= data_i;
                        scan_mask  <= '0;
                        bit_cnt    <= '0;
`ifdef MASK_GEN_CHGCNT_EN
                        chg_acc    <= '0;
`endif
                    end
                end
                ST_SCAN: begin
                    scan_mask <= scan_mask_nxt;
                    bit_cnt   <= last_bit ? '0 : bit_cnt + BIT_W'(1);
`ifdef MASK_GEN_CHGCNT_EN
                    chg_acc   <= chg_acc_nxt;
`endif
                    if (emit_hit) begin
                        mask_o            <= scan_mask_nxt;
                        data_o            <= data_latch;
                        ref_reg           <= data_latch;
                        outsignal_pulse_o <= 1'b1;
`ifdef MASK_GEN_CHGCNT_EN
                        change_cnt_o      <= chg_acc_nxt;
`endif
                    end
                end
                ST_EMIT: begin
                    guard_cnt <= '0;
                end
                ST_GUARD: begin
                    guard_cnt <= guard_cnt + GUARD_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mask_gen.sv
// ---------------------------------------------------------------------------
// tb_mask_gen
//
// Self-checking bench for mask_gen. A directed table covers the documented
// scenarios, a held-valid sequence and a mid-scan reset cover the multi-cycle
// corners, and a randomized run is checked against a word-level model that
// remembers the last published word and derives mask, strobe timing and
// ready timing from it. Compile with MASK_GEN_CHGCNT_EN to also check
// change_cnt_o.
// ---------------------------------------------------------------------------
module tb_mask_gen;

    localparam int DL = 8;
    localparam int GC = 10;

    logic          clk_i;
    logic          rst_N_i;
    logic          data_valid_i;
    logic [DL-1:0] data_i;
    logic          data_ready_o;
    logic [DL-1:0] mask_o;
    logic [DL-1:0] data_o;
    logic          outsignal_pulse_o;
    logic          busy_o;
`ifdef MASK_GEN_CHGCNT_EN
    logic [$clog2(DL+1)-1:0] change_cnt_o;
`endif

    int n_compared;
    int n_mismatched;

    logic [DL-1:0] model_ref;
    logic [DL-1:0] cur_mask;
    logic [DL-1:0] cur_data;

    typedef struct {
        logic [DL-1:0] data;
        logic [DL-1:0] exp_mask;
        logic [DL-1:0] exp_data;
        logic          exp_pulse;
    } vec_t;

    vec_t vecs[7];

    mask_gen #(
        .DATA_LEN (DL),
        .MASK_LEN (DL),
        .GUARD_CYC(GC)
    ) dut (
        .clk_i            (clk_i),
        .rst_N_i          (rst_N_i),
        .data_valid_i     (data_valid_i),
        .data_i           (data_i),
        .data_ready_o     (data_ready_o),
        .mask_o           (mask_o),
        .data_o           (data_o),
        .outsignal_pulse_o(outsignal_pulse_o),
        .busy_o           (busy_o)
`ifdef MASK_GEN_CHGCNT_EN
        ,
        .change_cnt_o     (change_cnt_o)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Watchdog so a stuck DUT still ends the run with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [DL-1:0] msk);
`ifdef MASK_GEN_CHGCNT_EN
        check_output(name, 32'(change_cnt_o), 32'($countones(msk)));
`else
        if (msk === 'x) $display("[TB] unreachable %s", name);
`endif
    endtask

    // Waits (from a negedge) for ready with valid asserted; returns with the
    // next posedge being the handshake edge when got is set.
    task automatic wait_ready(output bit got);
        got = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (data_ready_o === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        check_output("accept_wait", 32'(got), 32'd1);
    endtask

    // Sends one word and checks every cycle from the handshake until ready
    // returns. Cycle k is the k-th negedge after the handshake edge. With
    // hold set, valid stays high and data_i is scrambled while busy, then
    // next_w is presented on the cycle ready returns.
    task automatic apply_stimulus(input logic [DL-1:0] w, input logic [DL-1:0] exp_mask,
                                  input logic [DL-1:0] exp_data, input bit exp_changed,
                                  input bit hold, input logic [DL-1:0] next_w);
        int  ready_k;
        bit  got;
        bit  new_now;
        ready_k      = exp_changed ? DL + 2 + GC : DL + 2;
        data_i       = w;
        data_valid_i = 1'b1;
        wait_ready(got);
        if (!got) begin
            data_valid_i = 1'b0;
            return;
        end
        @(posedge clk_i);
        for (int k = 1; k <= ready_k; k++) begin
            @(negedge clk_i);
            new_now = !exp_changed || (k >= DL + 1);
            check_output($sformatf("pulse w=%0h k=%0d", w, k), 32'(outsignal_pulse_o),
                         32'(exp_changed && (k == DL + 1)));
            check_output($sformatf("ready w=%0h k=%0d", w, k), 32'(data_ready_o), 32'(k == ready_k));
            check_output($sformatf("busy w=%0h k=%0d", w, k), 32'(busy_o), 32'(k != ready_k));
            check_output($sformatf("mask w=%0h k=%0d", w, k), 32'(mask_o),
                         32'(new_now ? exp_mask : cur_mask));
            check_output($sformatf("data w=%0h k=%0d", w, k), 32'(data_o),
                         32'(new_now ? exp_data : cur_data));
            check_cnt($sformatf("cnt w=%0h k=%0d", w, k), new_now ? exp_mask : cur_mask);
            if (hold) begin
                data_valid_i = 1'b1;
                data_i       = (k == ready_k) ? next_w : DL'($urandom);
            end else begin
                data_valid_i = 1'b0;
                data_i       = DL'($urandom);
            end
        end
        cur_mask = exp_mask;
        cur_data = exp_data;
    endtask

    // Word-level reference: the mask is the XOR with the last published
    // word, and only a nonzero mask publishes and becomes the new reference.
    task automatic send_model(input logic [DL-1:0] w, input bit hold, input logic [DL-1:0] next_w);
        logic [DL-1:0] m;
        m = w ^ model_ref;
        if (m != '0) begin
            apply_stimulus(w, m, w, 1'b1, hold, next_w);
            model_ref = w;
        end else begin
            apply_stimulus(w, cur_mask, cur_data, 1'b0, hold, next_w);
        end
    endtask

    // Main sequence: reset, directed table, held valid, random, mid-scan reset.
    initial begin
        bit got;
        n_compared   = 0;
        n_mismatched = 0;
        model_ref    = '0;
        cur_mask     = '0;
        cur_data     = '0;
        rst_N_i      = 1'b0;
        data_valid_i = 1'b0;
        data_i       = '0;

        vecs[0] = '{data: 8'hA5, exp_mask: 8'hA5, exp_data: 8'hA5, exp_pulse: 1'b1};
        vecs[1] = '{data: 8'hA5, exp_mask: 8'hA5, exp_data: 8'hA5, exp_pulse: 1'b0};
        vecs[2] = '{data: 8'h3C, exp_mask: 8'h99, exp_data: 8'h3C, exp_pulse: 1'b1};
        vecs[3] = '{data: 8'h3C, exp_mask: 8'h99, exp_data: 8'h3C, exp_pulse: 1'b0};
        vecs[4] = '{data: 8'h00, exp_mask: 8'h3C, exp_data: 8'h00, exp_pulse: 1'b1};
        vecs[5] = '{data: 8'hFF, exp_mask: 8'hFF, exp_data: 8'hFF, exp_pulse: 1'b1};
        vecs[6] = '{data: 8'h81, exp_mask: 8'h7E, exp_data: 8'h81, exp_pulse: 1'b1};

        repeat (2) @(negedge clk_i);
        rst_N_i = 1'b1;
        #1;
        check_output("init ready", 32'(data_ready_o), 32'd0);
        check_output("init busy", 32'(busy_o), 32'd1);
        check_output("init mask", 32'(mask_o), 32'd0);
        check_output("init data", 32'(data_o), 32'd0);
        check_output("init pulse", 32'(outsignal_pulse_o), 32'd0);
        check_cnt("init cnt", 8'h00);
        @(negedge clk_i);
        check_output("idle ready", 32'(data_ready_o), 32'd1);
        check_output("idle busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].data, vecs[i].exp_mask, vecs[i].exp_data,
                           vecs[i].exp_pulse, 1'b0, '0);
            if (vecs[i].exp_pulse) model_ref = vecs[i].data;
        end

        send_model(8'h5A, 1'b1, 8'h24);
        send_model(8'h24, 1'b0, '0);

        for (int i = 0; i < 40; i++) begin
            logic [DL-1:0] w;
            w = ($urandom_range(0, 3) == 0) ? model_ref : DL'($urandom);
            send_model(w, ($urandom_range(0, 4) == 0), model_ref ^ DL'($urandom_range(0, 255)));
        end

        send_model(8'h7E, 1'b0, '0);
        if (model_ref == '0) send_model(8'h7E, 1'b0, '0);

        data_i       = 8'hFF;
        data_valid_i = 1'b1;
        wait_ready(got);
        if (got) begin
            @(posedge clk_i);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk_i);
                data_valid_i = 1'b0;
            end
            #2;
            rst_N_i = 1'b0;
            #1;
            check_output("rst mask", 32'(mask_o), 32'd0);
            check_output("rst data", 32'(data_o), 32'd0);
            check_output("rst pulse", 32'(outsignal_pulse_o), 32'd0);
            check_output("rst ready", 32'(data_ready_o), 32'd0);
            check_cnt("rst cnt", 8'h00);
            @(negedge clk_i);
            @(negedge clk_i);
            rst_N_i = 1'b1;
            #1;
            check_output("rst init ready", 32'(data_ready_o), 32'd0);
            check_output("rst init pulse", 32'(outsignal_pulse_o), 32'd0);
            @(negedge clk_i);
            check_output("rst idle ready", 32'(data_ready_o), 32'd1);
            model_ref = '0;
            cur_mask  = '0;
            cur_data  = '0;
            apply_stimulus(8'h01, 8'h01, 8'h01, 1'b1, 1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
